regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 24: register width in bits.
REQ-002 Parameter DEPTH, default 16: number of registers, 2..256, not required to be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width; not overridden by instantiators.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 wr_en  in  1; wr_addr  in  ADDR_W; wr_data  in  DATA_W: write port.
REQ-007 rd0_en  in  1; rd0_addr  in  ADDR_W: read port 0 request.
REQ-008 rd0_data  out  DATA_W; rd0_valid  out  1: read port 0 response.
REQ-009 rd1_en, rd1_addr, rd1_data, rd1_valid: read port 1, identical to port 0.
REQ-010 rsv_en  in  1; rsv_addr  in  ADDR_W: reservation request, marks a register busy.
REQ-011 rsv_ok  out  1: combinational, high when rsv_addr is in range and not busy.
REQ-012 busy  out  DEPTH: registered per-register busy flags.
REQ-013 busy_cnt  out  ADDR_W+1: registered count of set busy flags.

Function
REQ-014 Write: wr_en at edge t with in-range wr_addr stores wr_data; it is visible to reads sampled at edge t+1.
REQ-015 Write: wr_en clears busy[wr_addr] at the same edge; writes are accepted regardless of busy state.
REQ-016 Read latency: rdN_en sampled at edge t drives rdN_data/rdN_valid after edge t, i.e. one cycle.
REQ-017 Read success: rdN_valid is high for exactly one cycle when the addressed register is not busy at edge t; rdN_data then carries its contents.
REQ-018 Read failure: when the register is busy, rdN_valid is 0 and rdN_data holds its previous value.
REQ-019 Read idle: rdN_valid is 0 and rdN_data holds when rdN_en is low.
REQ-020 Both read ports are independent, and both may address the same register in one cycle.
REQ-021 Reservation: rsv_en with rsv_ok high sets busy[rsv_addr] at the edge; rsv_en with rsv_ok low is ignored.
REQ-022 Simultaneous accepted reservation and write to the same address: the write data is stored and busy ends set.
REQ-023 Simultaneous write and rejected reservation to the same address: busy ends clear.
REQ-024 busy_cnt: each edge it changes by (+1 per newly set flag) and (-1 per newly cleared flag), net range 0..DEPTH, with no wrap.
REQ-025 Out-of-range address (>= DEPTH): writes and reservations are ignored; reads give rdN_valid 1 and rdN_data 0.
REQ-026 Same-cycle read and write to the same address without bypass: the read returns the old contents and uses the pre-write busy flag.

Reset
REQ-027 rst clears all registers, busy, busy_cnt, rd0_data, rd1_data, rd0_valid and rd1_valid to 0 at the sampling edge.
REQ-028 rst takes priority over all same-cycle requests; reads, writes and reservations in a reset cycle are dropped.
REQ-029 The first edge after rst deasserts processes requests normally; there is no recovery cycle.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN: when defined, a read sampled in the same cycle as an in-range write to the same address returns wr_data with rdN_valid 1, even if busy.
REQ-031 Without REGFILE_BYPASS_EN, REQ-026 applies and no bypass mux is built.

Structure
REQ-032 Package regfile_pkg holds the DATA_W/DEPTH defaults and a typedef for the read-response struct (data, valid).
REQ-033 Sub-module regfile_scoreboard owns the busy flags, busy_cnt and rsv_ok; regfile_mp owns the storage and the read ports.

Verification
REQ-034 Reset, then write 0xAAAAAA to reg 0 and read it on both ports next cycle -> both ports valid=1, data=0xAAAAAA one cycle later.
REQ-035 Reserve reg 3, then read reg 3 -> busy[3]=1, busy_cnt=1, rd0_valid=0; write 0x123456 to reg 3, then read -> valid=1, data=0x123456, busy_cnt=0.
REQ-036 Reserve reg 5 twice -> second rsv_ok=0 and busy_cnt stays 1; reserve and write reg 5 in the same cycle -> busy[5] ends 1 (per REQ-022/023).
REQ-037 Write 0xCCCCCC and read reg 2 in the same cycle -> data 0xCCCCCC with REGFILE_BYPASS_EN, old value 0 without.
REQ-038 Reserve all 16 regs -> busy_cnt=16 with no wrap; assert rst mid-stream with pending reads -> all outputs 0 next cycle and busy_cnt=0.
REQ-039 DEPTH=12: write and read addr 13 -> no state change, rd0_valid=1, rd0_data=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 24;
  localparam int RF_DEPTH  = 16;

  // One read-port response at the default data width.
  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic                 valid;
  } rd_resp_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reservations set a flag, writes clear it.
// A reservation that is accepted in the same cycle as a write to the same
// register wins, so the register stays busy. busy_cnt follows the flags
// incrementally. At most one flag rises and one falls per cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] r_busy;
  logic [ADDR_W:0]  r_busy_cnt;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  w_cnt_next;
  logic             w_wr_in_range;
  logic             w_rsv_in_range;
  logic             w_rsv_take;
  logic             w_inc;
  logic             w_dec;

  assign w_wr_in_range  = int'(wr_addr) < DEPTH;
  assign w_rsv_in_range = int'(rsv_addr) < DEPTH;
  assign rsv_ok         = w_rsv_in_range && !r_busy[rsv_addr];
  assign w_rsv_take     = rsv_en && rsv_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flag
      assign w_set[gi]       = w_rsv_take && (rsv_addr == ADDR_W'(gi));
      assign w_clr[gi]       = wr_en && w_wr_in_range && (wr_addr == ADDR_W'(gi));
      assign w_busy_next[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
    end
  endgenerate

  // A set only ever lands on an idle flag; a clear counts only if it really drops one.
  assign w_inc      = |(w_set & ~r_busy);
  assign w_dec      = |(w_clr & r_busy & ~w_set);
  assign w_cnt_next = r_busy_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};

  // Busy flags and their population count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, two registered read ports and a busy
// scoreboard for reservations. Optional macro REGFILE_BYPASS_EN forwards a
// same-cycle write to a matching read (ignoring busy); without it a read
// sees the pre-write contents and busy flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_in_range;
  logic              w_rd_en   [2];
  logic [ADDR_W-1:0] w_rd_addr [2];

  assign w_wr_in_range = int'(wr_addr) < DEPTH;
  assign w_rd_en[0]    = rd0_en;
  assign w_rd_en[1]    = rd1_en;
  assign w_rd_addr[0]  = rd0_addr;
  assign w_rd_addr[1]  = rd1_addr;

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy     (w_busy),
    .busy_cnt (busy_cnt)
  );

  // Storage: cleared on reset, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en && w_wr_in_range) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] r_data;
      logic              r_valid;
      logic              w_in_range;

      assign w_in_range = int'(w_rd_addr[gi]) < DEPTH;
`ifdef REGFILE_BYPASS_EN
      logic w_hit;
      assign w_hit = wr_en && w_wr_in_range && (wr_addr == w_rd_addr[gi]);
`endif

      // One-cycle read response; data holds whenever the read is not valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (!w_rd_en[gi]) begin
          r_valid <= 1'b0;
        end else if (!w_in_range) begin
          r_data  <= '0;
          r_valid <= 1'b1;
`ifdef REGFILE_BYPASS_EN
        end else if (w_hit) begin
          r_data  <= wr_data;
          r_valid <= 1'b1;
`endif
        end else if (!w_busy[w_rd_addr[gi]]) begin
          r_data  <= r_mem[w_rd_addr[gi]];
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd0_data  = g_rd[0].r_data;
  assign rd0_valid = g_rd[0].r_valid;
  assign rd1_data  = g_rd[1].r_data;
  assign rd1_valid = g_rd[1].r_valid;
  assign busy      = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: table of vectors through a scoreboard queue, plus
// hand sequences for bypass, full reservation, mid-stream reset and a
// DEPTH=12 instance exercising out-of-range addresses.
module tb_regfile_mp;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic        rst, wr_en, rd0_en, rd1_en, rsv_en;
  logic [3:0]  wr_addr, rd0_addr, rd1_addr, rsv_addr;
  logic [23:0] wr_data, rd0_data, rd1_data;
  logic        rd0_valid, rd1_valid, rsv_ok;
  logic [15:0] busy;
  logic [4:0]  busy_cnt;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy(busy), .busy_cnt(busy_cnt)
  );

  // DEPTH=12 instance
  logic        e_wr_en, e_rd0_en, e_rd1_en, e_rsv_en;
  logic [3:0]  e_wr_addr, e_rd0_addr, e_rd1_addr, e_rsv_addr;
  logic [23:0] e_wr_data, e_rd0_data, e_rd1_data;
  logic        e_rd0_valid, e_rd1_valid, e_rsv_ok;
  logic [11:0] e_busy;
  logic [4:0]  e_busy_cnt;

  regfile_mp #(.DEPTH(12)) dut12 (
    .clk(clk), .rst(rst),
    .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .rd0_en(e_rd0_en), .rd0_addr(e_rd0_addr), .rd0_data(e_rd0_data), .rd0_valid(e_rd0_valid),
    .rd1_en(e_rd1_en), .rd1_addr(e_rd1_addr), .rd1_data(e_rd1_data), .rd1_valid(e_rd1_valid),
    .rsv_en(e_rsv_en), .rsv_addr(e_rsv_addr), .rsv_ok(e_rsv_ok),
    .busy(e_busy), .busy_cnt(e_busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        rd0_en;
    logic [3:0]  rd0_addr;
    logic        rd1_en;
    logic [3:0]  rd1_addr;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        exp_ok;
    rd_resp_t    exp_rd0;
    rd_resp_t    exp_rd1;
    logic [15:0] exp_busy;
    logic [4:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    rd_resp_t    rd0;
    rd_resp_t    rd1;
    logic [15:0] busy;
    logic [4:0]  cnt;
  } obs_t;

  obs_t sb_q[$];
  vec_t tbl[14];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic we, input logic [3:0] wa, input logic [23:0] wd,
    input logic e0, input logic [3:0] a0, input logic e1, input logic [3:0] a1,
    input logic re, input logic [3:0] ra, input logic ok,
    input logic [23:0] d0, input logic v0, input logic [23:0] d1, input logic v1,
    input logic [15:0] b, input logic [4:0] c);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd0_en = e0; v.rd0_addr = a0; v.rd1_en = e1; v.rd1_addr = a1;
    v.rsv_en = re; v.rsv_addr = ra; v.exp_ok = ok;
    v.exp_rd0.data = d0; v.exp_rd0.valid = v0;
    v.exp_rd1.data = d1; v.exp_rd1.valid = v1;
    v.exp_busy = b; v.exp_cnt = c;
    return v;
  endfunction

  // One DEPTH=16 transaction: drive on negedge, check rsv_ok, score after the edge.
  task automatic cycle(input string tag, input vec_t v);
    obs_t o;
    obs_t e;
    @(negedge clk);
    rst = v.rst; wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
    rd0_en = v.rd0_en; rd0_addr = v.rd0_addr; rd1_en = v.rd1_en; rd1_addr = v.rd1_addr;
    rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
    #1;
    chk({tag, " rsv_ok"}, {63'd0, rsv_ok}, {63'd0, v.exp_ok});
    o.rd0 = v.exp_rd0; o.rd1 = v.exp_rd1; o.busy = v.exp_busy; o.cnt = v.exp_cnt;
    sb_q.push_back(o);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, " rd0_valid"}, {63'd0, rd0_valid}, {63'd0, e.rd0.valid});
    chk({tag, " rd0_data"}, {40'd0, rd0_data}, {40'd0, e.rd0.data});
    chk({tag, " rd1_valid"}, {63'd0, rd1_valid}, {63'd0, e.rd1.valid});
    chk({tag, " rd1_data"}, {40'd0, rd1_data}, {40'd0, e.rd1.data});
    chk({tag, " busy"}, {48'd0, busy}, {48'd0, e.busy});
    chk({tag, " busy_cnt"}, {59'd0, busy_cnt}, {59'd0, e.cnt});
    $display("%s: rd0=%06h/%0b rd1=%06h/%0b busy=%04h cnt=%0d", tag,
             rd0_data, rd0_valid, rd1_data, rd1_valid, busy, busy_cnt);
  endtask

  // One DEPTH=12 transaction with inline checks.
  task automatic cyc12(input string tag,
    input logic we, input logic [3:0] wa, input logic [23:0] wd,
    input logic e0, input logic [3:0] a0, input logic e1, input logic [3:0] a1,
    input logic re, input logic [3:0] ra, input logic ok,
    input logic [23:0] d0, input logic v0, input logic [23:0] d1, input logic v1);
    @(negedge clk);
    e_wr_en = we; e_wr_addr = wa; e_wr_data = wd;
    e_rd0_en = e0; e_rd0_addr = a0; e_rd1_en = e1; e_rd1_addr = a1;
    e_rsv_en = re; e_rsv_addr = ra;
    #1;
    chk({tag, " rsv_ok"}, {63'd0, e_rsv_ok}, {63'd0, ok});
    @(posedge clk);
    #1;
    chk({tag, " rd0_valid"}, {63'd0, e_rd0_valid}, {63'd0, v0});
    chk({tag, " rd0_data"}, {40'd0, e_rd0_data}, {40'd0, d0});
    chk({tag, " rd1_valid"}, {63'd0, e_rd1_valid}, {63'd0, v1});
    chk({tag, " rd1_data"}, {40'd0, e_rd1_data}, {40'd0, d1});
    chk({tag, " busy"}, {52'd0, e_busy}, 64'd0);
    chk({tag, " busy_cnt"}, {59'd0, e_busy_cnt}, 64'd0);
    $display("%s: rd0=%06h/%0b rd1=%06h/%0b busy=%03h cnt=%0d", tag,
             e_rd0_data, e_rd0_valid, e_rd1_data, e_rd1_valid, e_busy, e_busy_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] m;
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd0_en = 0; rd0_addr = 0;
    rd1_en = 0; rd1_addr = 0; rsv_en = 0; rsv_addr = 0;
    e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_rd0_en = 0; e_rd0_addr = 0;
    e_rd1_en = 0; e_rd1_addr = 0; e_rsv_en = 0; e_rsv_addr = 0;
    @(posedge clk);
    @(posedge clk);

    //          rst we wa   wd          e0 a0 e1 a1 re ra ok  rd0            rd1            busy       cnt
    tbl[0]  = mk(1, 1, 1, 24'h000005, 1, 0, 1, 0, 1, 2, 1, 24'h0, 0,      24'h0, 0,      16'h0000, 0);
    tbl[1]  = mk(0, 1, 0, 24'hAAAAAA, 0, 0, 0, 0, 0, 0, 1, 24'h0, 0,      24'h0, 0,      16'h0000, 0);
    tbl[2]  = mk(0, 0, 0, 24'h0,      1, 0, 1, 0, 0, 0, 1, 24'hAAAAAA, 1, 24'hAAAAAA, 1, 16'h0000, 0);
    tbl[3]  = mk(0, 0, 0, 24'h0,      0, 0, 0, 0, 1, 3, 1, 24'hAAAAAA, 0, 24'hAAAAAA, 0, 16'h0008, 1);
    tbl[4]  = mk(0, 0, 0, 24'h0,      1, 3, 0, 0, 0, 3, 0, 24'hAAAAAA, 0, 24'hAAAAAA, 0, 16'h0008, 1);
    tbl[5]  = mk(0, 1, 3, 24'h123456, 0, 0, 0, 0, 0, 3, 0, 24'hAAAAAA, 0, 24'hAAAAAA, 0, 16'h0000, 0);
    tbl[6]  = mk(0, 0, 0, 24'h0,      1, 3, 1, 0, 0, 3, 1, 24'h123456, 1, 24'hAAAAAA, 1, 16'h0000, 0);
    tbl[7]  = mk(0, 0, 0, 24'h0,      0, 0, 0, 0, 1, 5, 1, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0020, 1);
    tbl[8]  = mk(0, 0, 0, 24'h0,      0, 0, 0, 0, 1, 5, 0, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0020, 1);
    tbl[9]  = mk(0, 1, 5, 24'h555555, 0, 0, 0, 0, 1, 5, 0, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0000, 0);
    tbl[10] = mk(0, 1, 5, 24'h666666, 0, 0, 0, 0, 1, 5, 1, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0020, 1);
    tbl[11] = mk(0, 0, 0, 24'h0,      1, 5, 1, 5, 0, 5, 0, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0020, 1);
    tbl[12] = mk(0, 1, 5, 24'h777777, 0, 0, 0, 0, 0, 5, 0, 24'h123456, 0, 24'hAAAAAA, 0, 16'h0000, 0);
    tbl[13] = mk(0, 0, 0, 24'h0,      1, 5, 1, 2, 0, 5, 1, 24'h777777, 1, 24'h0, 1,      16'h0000, 0);

    for (int i = 0; i < 14; i++) cycle($sformatf("vec%0d", i), tbl[i]);

    // Same-cycle write and read of reg 2
    cycle("same_cycle_rw", mk(0, 1, 2, 24'hCCCCCC, 1, 2, 0, 0, 0, 0, 1,
                              BYP ? 24'hCCCCCC : 24'h0, 1, 24'h0, 0, 16'h0000, 0));
    cycle("read_back_r2", mk(0, 0, 0, 24'h0, 1, 2, 1, 2, 0, 0, 1,
                             24'hCCCCCC, 1, 24'hCCCCCC, 1, 16'h0000, 0));

    // Reserve every register
    for (int i = 0; i < 16; i++) begin
      m = (32'd1 << (i + 1)) - 32'd1;
      cycle($sformatf("rsv_all%0d", i), mk(0, 0, 0, 24'h0, 0, 0, 0, 0, 1, 4'(i), 1,
            24'hCCCCCC, 0, 24'hCCCCCC, 0, m[15:0], 5'(i + 1)));
    end
    cycle("rsv_full", mk(0, 0, 0, 24'h0, 1, 7, 0, 0, 1, 0, 0,
                         24'hCCCCCC, 0, 24'hCCCCCC, 0, 16'hFFFF, 16));

    // Reset with requests pending on every port
    cycle("mid_reset", mk(1, 1, 1, 24'h111111, 1, 2, 1, 2, 1, 0, 0,
                          24'h0, 0, 24'h0, 0, 16'h0000, 0));
    cycle("post_reset", mk(0, 1, 1, 24'h111111, 1, 0, 1, 1, 1, 4, 1,
                           24'h0, 1, BYP ? 24'h111111 : 24'h0, 1, 16'h0010, 1));
    cycle("post_reset2", mk(0, 0, 0, 24'h0, 1, 1, 1, 4, 0, 4, 0,
                            24'h111111, 1, BYP ? 24'h111111 : 24'h0, 0, 16'h0010, 1));

    // DEPTH=12: out-of-range addresses
    cyc12("d12_oor_wr", 1, 13, 24'hABCDEF, 1, 13, 0, 0, 1, 13, 0, 24'h0, 1, 24'h0, 0);
    cyc12("d12_edge_wr", 1, 11, 24'h0BBBBB, 0, 0, 1, 12, 0, 0, 1, 24'h0, 0, 24'h0, 1);
    cyc12("d12_edge_rd", 0, 0, 24'h0, 1, 11, 1, 13, 0, 11, 1, 24'h0BBBBB, 1, 24'h0, 1);
    cyc12("d12_alias_rd", 0, 0, 24'h0, 1, 1, 0, 0, 0, 1, 1, 24'h0, 1, 24'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
